// File: rtl/pipe_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_tracker
// Tracks in-flight destinations after decode to drive forwarding selects,
// the load-use stall and saturating stall/flush/retire counters.
// Rev    : 1.0
// ============================================================================
module pipe_hazard_tracker #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 16,
  parameter int FW_W     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              flush,
  input  logic              stall_ext,
  input  logic              clr_cnt,
  output logic              id_ready,
  output logic              stall,
  output logic [FW_W-1:0]   fwd_a,
  output logic [FW_W-1:0]   fwd_b,
  output logic [DEPTH-1:0]  stage_valid,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  we_q, we_d;
  logic [DEPTH-1:0]  load_q, load_d;
  logic [ADDR_W-1:0] rd_q [DEPTH];
  logic [ADDR_W-1:0] rd_d [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [FW_W:0]     w_look_a, w_look_b;

  // Returns {hazard, select}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [FW_W:0] lookup(input logic [ADDR_W-1:0] src, input logic used);
    logic [FW_W:0] res;
    res = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (used && (src != '0) && valid_q[i] && we_q[i] && (rd_q[i] == src))
        res = {load_q[i] && (i < LOAD_RDY), FW_W'(i + 1)};
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic inc);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (clr_cnt)
      res = '0;
    else if (inc && (cnt != C_CNT_MAX))
      res = cnt + CNT_W'(1);
    return res;
  endfunction

  always_comb begin
    w_look_a    = lookup(id_rs, id_rs_used);
    w_look_b    = lookup(id_rt, id_rt_used);
    fwd_a       = w_look_a[FW_W-1:0];
    fwd_b       = w_look_b[FW_W-1:0];
    stall       = id_valid && !flush && (w_look_a[FW_W] || w_look_b[FW_W]);
    id_ready    = id_valid && !stall && !stall_ext && !flush;
    stage_valid = valid_q;
    wb_we       = valid_q[DEPTH-1] && we_q[DEPTH-1];
    wb_rd       = rd_q[DEPTH-1];
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
    retire_cnt  = retire_cnt_q;
  end

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    load_d  = load_q;
    rd_d    = rd_q;
    if (!stall_ext) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        valid_d[i] = valid_q[i-1];
        we_d[i]    = we_q[i-1];
        load_d[i]  = load_q[i-1];
        rd_d[i]    = rd_q[i-1];
      end
      // Anything not accepted this cycle enters as an all-zero bubble.
      valid_d[0] = id_ready;
      we_d[0]    = id_ready && id_we && (id_rd != '0);
      load_d[0]  = id_ready && id_load;
      rd_d[0]    = id_ready ? id_rd : '0;
    end
    stall_cnt_d  = cnt_next(stall_cnt_q,  stall && !stall_ext);
    flush_cnt_d  = cnt_next(flush_cnt_q,  flush && id_valid && !stall_ext);
    retire_cnt_d = cnt_next(retire_cnt_q, valid_q[DEPTH-1] && !stall_ext);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q      <= '0;
      we_q         <= '0;
      load_q       <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      we_q         <= we_d;
      load_q       <= load_d;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_tracker
// Self-checking bench: vector table, hand sequences and random stimulus
// against a queue-based model. Rev 1.0
// ============================================================================
module tb_pipe_hazard_tracker;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_RDY = 2;
  localparam int FW_W     = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0, id_we = 1'b0, id_load = 1'b0;
  logic flush = 1'b0, stall_ext = 1'b0, clr_cnt = 1'b0;
  logic [ADDR_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;

  logic id_ready, stall, wb_we;
  logic [FW_W-1:0] fwd_a, fwd_b;
  logic [DEPTH-1:0] stage_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [15:0] stall_cnt, flush_cnt, retire_cnt;

  logic id_ready2, stall2, wb_we2;
  logic [FW_W-1:0] fwd_a2, fwd_b2;
  logic [DEPTH-1:0] stage_valid2;
  logic [ADDR_W-1:0] wb_rd2;
  logic [1:0] stall_cnt2, flush_cnt2, retire_cnt2;

  always #5 CLK = ~CLK;

  pipe_hazard_tracker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .flush(flush), .stall_ext(stall_ext), .clr_cnt(clr_cnt),
    .id_ready(id_ready), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stage_valid(stage_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt));

  pipe_hazard_tracker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .flush(flush), .stall_ext(stall_ext), .clr_cnt(clr_cnt),
    .id_ready(id_ready2), .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .stage_valid(stage_valid2), .wb_we(wb_we2), .wb_rd(wb_rd2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .retire_cnt(retire_cnt2));

  typedef struct {
    int v, rs, rt, rsu, rtu, rd, we, ld, fl, sx, clr;
    int e_stall, e_ready, e_fa, e_fb;   // -1 = model-only
  } vec_t;

  typedef struct packed {
    logic v, we, ld;
    logic [ADDR_W-1:0] rd;
  } ent_t;

  ent_t pipe [$];   // index 0 = youngest (execute)
  int m_sc, m_fc, m_rc, m2_sc, m2_fc, m2_rc;
  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int v, rs, rt, rsu, rtu, rd, we, ld, fl,
                              input int es, er, efa, efb);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rsu = rsu; r.rtu = rtu; r.rd = rd;
    r.we = we; r.ld = ld; r.fl = fl; r.sx = 0; r.clr = 0;
    r.e_stall = es; r.e_ready = er; r.e_fa = efa; r.e_fb = efb;
    return r;
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x < mx) ? x + 1 : mx;
  endfunction

  function automatic int model_fwd(input int src, input int used);
    if (used == 0 || src == 0) return 0;
    for (int k = 0; k < pipe.size(); k++)
      if (pipe[k].v && pipe[k].we && int'(pipe[k].rd) == src) return k + 1;
    return 0;
  endfunction

  task automatic model_reset();
    pipe = {};
    repeat (DEPTH) pipe.push_back('0);
    m_sc = 0; m_fc = 0; m_rc = 0; m2_sc = 0; m2_fc = 0; m2_rc = 0;
  endtask

  task automatic check_state();
    int sv;
    sv = 0;
    for (int k = 0; k < DEPTH; k++) if (pipe[k].v) sv += (1 << k);
    chk("stage_valid", int'(stage_valid), sv);
    chk("wb_we", int'(wb_we), int'(pipe[DEPTH-1].v && pipe[DEPTH-1].we));
    chk("wb_rd", int'(wb_rd), int'(pipe[DEPTH-1].rd));
    chk("stall_cnt", int'(stall_cnt), m_sc);
    chk("flush_cnt", int'(flush_cnt), m_fc);
    chk("retire_cnt", int'(retire_cnt), m_rc);
    chk("stall_cnt_w2", int'(stall_cnt2), m2_sc);
    chk("flush_cnt_w2", int'(flush_cnt2), m2_fc);
    chk("retire_cnt_w2", int'(retire_cnt2), m2_rc);
  endtask

  // Entered with CLK low; returns at the following falling edge.
  task automatic run(input vec_t v);
    int fa, fb, ms, mr;
    bit ha, hb;
    ent_t e;
    id_valid = v.v[0]; id_rs = ADDR_W'(v.rs); id_rt = ADDR_W'(v.rt);
    id_rs_used = v.rsu[0]; id_rt_used = v.rtu[0]; id_rd = ADDR_W'(v.rd);
    id_we = v.we[0]; id_load = v.ld[0]; flush = v.fl[0];
    stall_ext = v.sx[0]; clr_cnt = v.clr[0];
    #1;
    fa = model_fwd(v.rs, v.rsu);
    fb = model_fwd(v.rt, v.rtu);
    ha = (fa != 0) && pipe[fa-1].ld && (fa - 1 < LOAD_RDY);
    hb = (fb != 0) && pipe[fb-1].ld && (fb - 1 < LOAD_RDY);
    ms = (v.v != 0 && v.fl == 0 && (ha || hb)) ? 1 : 0;
    mr = (v.v != 0 && ms == 0 && v.sx == 0 && v.fl == 0) ? 1 : 0;
    chk("stall", int'(stall), ms);
    chk("id_ready", int'(id_ready), mr);
    chk("fwd_a", int'(fwd_a), fa);
    chk("fwd_b", int'(fwd_b), fb);
    if (v.e_stall >= 0) begin
      chk("tbl_stall", int'(stall), v.e_stall);
      chk("tbl_ready", int'(id_ready), v.e_ready);
      chk("tbl_fwd_a", int'(fwd_a), v.e_fa);
      chk("tbl_fwd_b", int'(fwd_b), v.e_fb);
    end
    @(posedge CLK);
    if (v.sx == 0) begin
      if (ms != 0) begin m_sc = sat(m_sc, 65535); m2_sc = sat(m2_sc, 3); end
      if (v.fl != 0 && v.v != 0) begin m_fc = sat(m_fc, 65535); m2_fc = sat(m2_fc, 3); end
      if (pipe[DEPTH-1].v) begin m_rc = sat(m_rc, 65535); m2_rc = sat(m2_rc, 3); end
      e = '0;
      if (mr != 0) begin
        e.v = 1'b1; e.we = (v.we != 0 && v.rd != 0); e.ld = (v.ld != 0); e.rd = ADDR_W'(v.rd);
      end
      void'(pipe.pop_back());
      pipe.push_front(e);
    end
    if (v.clr != 0) begin
      m_sc = 0; m_fc = 0; m_rc = 0; m2_sc = 0; m2_fc = 0; m2_rc = 0;
    end
    #1;
    check_state();
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t w;
    int rc0;
    //            v rs rt su tu rd we ld fl  stall rdy fa fb
    tbl[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 1, 0, 0);  // add r3
    tbl[1]  = mk(1, 3, 3, 1, 1, 4, 1, 0, 0,  0, 1, 1, 1);  // sub r4,r3,r3
    tbl[2]  = mk(1, 3, 0, 1, 1, 5, 1, 0, 0,  0, 1, 2, 0);  // or r5,r3,r0
    tbl[3]  = mk(1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 1, 0, 0);  // lw r5
    tbl[4]  = mk(1, 5, 0, 1, 1, 6, 1, 0, 0,  1, 0, 1, 0);  // add r6,r5,r0
    tbl[5]  = mk(1, 5, 0, 1, 1, 6, 1, 0, 0,  1, 0, 2, 0);
    tbl[6]  = mk(1, 5, 0, 1, 1, 6, 1, 0, 0,  0, 1, 3, 0);
    tbl[7]  = mk(1, 9, 10, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0);  // writer to r0
    tbl[8]  = mk(1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 1, 0, 0);  // reader of r0
    tbl[9]  = mk(1, 1, 2, 1, 1, 7, 1, 0, 0,  0, 1, 0, 0);  // writer r7
    tbl[10] = mk(1, 7, 7, 1, 0, 12, 0, 0, 0, 0, 1, 1, 0);  // rt=7 unused
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 1, 0, 8, 1, 1, 0,  0, 1, 0, 0);  // lw r8
    tbl[13] = mk(1, 8, 0, 1, 1, 9, 1, 0, 0,  1, 0, 1, 0);  // add r9,r8 stalls
    tbl[14] = mk(1, 8, 0, 1, 1, 9, 1, 0, 1,  0, 0, 2, 0);  // flush wins
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    model_reset();
    id_valid = 1'b1;
    #1;
    chk("reset_id_ready", int'(id_ready), 1);
    chk("reset_stall", int'(stall), 0);
    id_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_state();

    for (int i = 0; i < 16; i++) begin
      run(tbl[i]);
      if (i == 5)  chk("loaduse_bubbles", int'(stage_valid), 3'b100);
      if (i == 6)  chk("loaduse_stall_cnt", int'(stall_cnt), 2);
      if (i == 14) begin
        chk("flush_cnt_once", int'(flush_cnt), 1);
        chk("flush_stall_cnt_held", int'(stall_cnt), 3);
        chk("flush_bubble", int'(stage_valid[0]), 0);
      end
    end

    // Asynchronous reset with a full pipeline
    for (int i = 0; i < 3; i++) run(mk(1, 0, 0, 0, 0, 20 + i, 1, 0, 0, -1, -1, -1, -1));
    RST = 1'b1;
    #1;
    chk("async_rst_stage_valid", int'(stage_valid), 0);
    chk("async_rst_stall_cnt", int'(stall_cnt), 0);
    chk("async_rst_flush_cnt", int'(flush_cnt), 0);
    chk("async_rst_retire_cnt", int'(retire_cnt), 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    run(mk(1, 0, 0, 0, 0, 14, 1, 0, 0, -1, -1, -1, -1));
    chk("post_rst_load", int'(stage_valid), 3'b001);

    // Freeze: fill, then hold four cycles
    for (int i = 0; i < 3; i++) run(mk(1, 0, 0, 0, 0, 1 + i, 1, 0, 0, -1, -1, -1, -1));
    rc0 = m_rc;
    for (int i = 0; i < 4; i++) begin
      w = mk(1, 3, 2, 1, 1, 15, 1, 0, 0, -1, -1, -1, -1);
      w.sx = 1;
      run(w);
      chk("freeze_retire", int'(retire_cnt), rc0);
      chk("freeze_stages", int'(stage_valid), 3'b111);
    end

    // Saturation of the 2-bit counters and clear priority
    w = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, -1, -1, -1, -1);
    w.clr = 1;
    run(w);
    for (int i = 0; i < 5; i++) run(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, -1, -1, -1, -1));
    chk("sat_retire_w2", int'(retire_cnt2), 3);
    chk("retire_w16", int'(retire_cnt), 5);
    run(w);
    chk("clr_with_retire", int'(retire_cnt), 0);
    chk("clr_with_retire_w2", int'(retire_cnt2), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      w = mk(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0) ? 1 : 0, -1, -1, -1, -1);
      w.sx  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      w.clr = ($urandom_range(0, 49) == 0) ? 1 : 0;
      run(w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_tracker.md
# pipe_hazard_tracker

Parametrised hazard and pipeline-occupancy tracker for the in-order MIPS pipeline. It tracks, per stage after decode, the destination register, write-enable and load flag of every in-flight instruction. From this it produces per-operand forwarding selects, the load-use stall and the decode-ready signal, plus saturating stall, flush and retire counters. It sits beside the decode stage and replaces fixed-depth hazard logic, so deeper pipelines (extra memory stages) reuse one block.

## Interface
- ADDR_W, 5, register-address width
- DEPTH, 3, tracked stages after decode (index 0 = execute, DEPTH-1 = writeback); legal 2..8
- LOAD_RDY, 2, lowest stage index whose load result may be forwarded; legal 1..DEPTH-1
- CNT_W, 16, counter width
- FW_W, derived = clog2(DEPTH+1), forwarding-select width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode holds a valid instruction
- id_rs, id_rt  in  ADDR_W  source registers
- id_rs_used, id_rt_used  in  1  source actually read
- id_rd  in  ADDR_W  destination register
- id_we  in  1  instruction writes register file
- id_load  in  1  instruction is a load
- flush  in  1  taken branch/jump: kill decode instruction
- stall_ext  in  1  external freeze of whole chain
- clr_cnt  in  1  synchronous counter clear
- id_ready  out  1  decode instruction advances this cycle
- stall  out  1  load-use stall
- fwd_a, fwd_b  out  FW_W  0 = register file, k = stage k-1 result
- stage_valid  out  DEPTH  per-stage valid
- wb_we  out  1  stage DEPTH-1 valid and writes
- wb_rd  out  ADDR_W  stage DEPTH-1 destination
- stall_cnt, flush_cnt, retire_cnt  out  CNT_W  saturating counters

## Operation
- Per stage registers: valid, we, load, rd. Entry written with we=0 when id_rd==0.
- Match for operand X (rs or rt): stage i is valid, has we=1, rd==X, X!=0, and X_used=1. Youngest matching stage (lowest i) wins.
- fwd_X = i+1 for the winning stage, else 0. Combinational from the current state and the decode inputs.
- Hazard on X: the winning stage has load=1 and i < LOAD_RDY.
- stall = id_valid & !flush & (hazard_a | hazard_b).
- id_ready = id_valid & !stall & !stall_ext & !flush.
- Advance, on each rising CLK when stall_ext=0:
  - stage[i] <= stage[i-1] for i>=1.
  - stage[0] <= decode fields with valid=1 when id_ready, else a bubble (all fields 0).
- stall_ext=1: all stage registers hold; counters hold except for a clear.
- Counters:
  - stall_cnt increments when stall & !stall_ext.
  - flush_cnt increments when flush & id_valid & !stall_ext.
  - retire_cnt increments when stage[DEPTH-1].valid & !stall_ext.
  - All counters saturate at 2^CNT_W-1. clr_cnt zeroes them, with priority over increment.
- flush with stall: flush wins. Bubble inserted, stall=0, stall_cnt unchanged.
- Combinational outputs are undefined-free for X-free inputs; no latches.

## Timing
- Reset values: all stage fields 0, counters 0, stall 0, fwd_a/fwd_b 0, stage_valid 0, wb_we 0, wb_rd 0. id_ready follows id_valid while stall_ext=0.
- RST takes effect immediately (asynchronous). Mid-operation it discards all in-flight entries; the first edge after release loads stage[0] normally.
- Latency: an instruction accepted at edge n appears in stage k after edge n+k with no stall_ext. It retires (leaves stage DEPTH-1) at edge n+DEPTH.
- Load-use stall length: a load in stage 0 forces LOAD_RDY stall cycles on a dependent decode instruction.
- fwd/stall settle in the same cycle as the decode inputs; no added register latency.

## Test plan
All scenarios use DEPTH=3, LOAD_RDY=2.
- Reset/idle: RST pulse mid-stream with 3 valid stages -> stage_valid=000, counters 0 immediately, before any clock edge.
- ALU chain: add r3 then sub r4,r3,r3 back-to-back -> on the sub cycle fwd_a=fwd_b=1, stall=0. One cycle later, a consumer of r3 sees fwd_a=2.
- Load-use: lw r5 followed by add r6,r5,r0:
  - stall=1 for 2 cycles, fwd_a=3 on release.
  - stall_cnt=2.
  - The stage_valid sequence shows bubbles in stage 0.
- Register zero / unused: writer to r0 followed by a reader of r0 -> fwd=0. Writer to r7 with id_rt_used=0 and id_rt=7 -> fwd_b=0.
- Flush/stall priority: flush asserted during an active load-use stall -> stall=0, id_ready=0, bubble in stage 0, flush_cnt=1, stall_cnt unchanged.
- Freeze and saturation:
  - stall_ext high for 4 cycles -> stage contents and retire_cnt frozen.
  - With CNT_W=2, 5 retirements -> retire_cnt=3.
  - clr_cnt together with a retire -> retire_cnt=0.
